slt_share_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared 64-bit set-less-than datapath (`slt_64`). It sits between the ALU `slt` path and the branch-compare path of the sequential core, which both need a 64-bit signed compare. It accepts one compare at a time by round-robin, registers the operands, and evaluates them through a single `slt_64` instance. It returns the registered result to the granted requester with a valid/ready handshake.

---
 rtl/slt_share_pkg.sv | 13 +
 rtl/slt_share_ctrl_slt64.sv | 21 ++
 rtl/slt_share_ctrl.sv | 148 ++++++++++++++
 tb/tb_slt_share_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/slt_share_pkg.sv
// Shared types for the 64-bit set-less-than share controller.
// Unsigned compares are enabled with SLT_SHARE_UNSIGNED_EN.
package slt_share_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } slt_state_e;

  typedef logic req_idx_t;
endpackage

// File: rtl/slt_share_ctrl_slt64.sv
// 64-bit subtract-based compare unit: a - b as a + ~b + 1.
// Signed less/overflow plus the raw carry-out for unsigned use.
module slt_64
  import slt_share_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            less,
  output logic            zero,
  output logic            ovf,
  output logic            cout
);

  logic [XLEN-1:0] diff;

  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
  assign ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);
  assign less = diff[XLEN-1] ^ ovf;
  assign zero = (diff == '0);

endmodule

// File: rtl/slt_share_ctrl.sv
// Round-robin two-requester front end for one shared slt_64.
// SLT_SHARE_UNSIGNED_EN adds per-requester unsigned compare.
module slt_share_ctrl
  import slt_share_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
`ifdef SLT_SHARE_UNSIGNED_EN
  input  logic            req0_unsigned,
  input  logic            req1_unsigned,
`endif
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic            rsp_less,
  output logic            rsp_zero,
  output logic            rsp_ovf
);

  localparam req_idx_t PRIO_RST = req_idx_t'(RR_INIT);

  slt_state_e      state_q, state_d;
  req_idx_t        prio_q, prio_d;
  req_idx_t        owner_q, owner_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            uns_q, uns_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic            less_q, less_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  req_idx_t grant;
  logic     accept;
  logic     uns_in0, uns_in1;
  logic     s_less, s_zero, s_ovf, s_cout;

`ifdef SLT_SHARE_UNSIGNED_EN
  assign uns_in0 = req0_unsigned;
  assign uns_in1 = req1_unsigned;
`else
  assign uns_in0 = 1'b0;
  assign uns_in1 = 1'b0;
`endif

  slt_64 u_slt (
    .a    (a_q),
    .b    (b_q),
    .less (s_less),
    .zero (s_zero),
    .ovf  (s_ovf),
    .cout (s_cout)
  );

  // Requester 1 wins when alone or when both are valid and it holds prio.
  assign grant = req_valid[1] & (~req_valid[0] | prio_q);

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE) begin
      req_ready[grant] = req_valid[grant];
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    less_d      = less_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          owner_d = grant;
          prio_d  = ~grant;
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          uns_d   = grant ? uns_in1 : uns_in0;
        end
      end
      CALC: begin
        state_d              = RESP;
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        less_d               = uns_q ? ~s_cout : s_less;
        zero_d               = s_zero;
        ovf_d                = uns_q ? 1'b0 : s_ovf;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d     = IDLE;
          rsp_valid_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= PRIO_RST;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      uns_q       <= 1'b0;
      rsp_valid_q <= '0;
      less_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      less_q      <= less_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_less  = less_q;
  assign rsp_zero  = zero_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_slt_share_ctrl.sv
// Directed bench for slt_share_ctrl with immediate-assertion checks.
// Unsigned cases run only when SLT_SHARE_UNSIGNED_EN is defined.
module tb_slt_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        rsp_less, rsp_zero, rsp_ovf;
`ifdef SLT_SHARE_UNSIGNED_EN
  logic        req0_unsigned, req1_unsigned;
`endif

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slt_share_ctrl #(.RR_INIT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
`ifdef SLT_SHARE_UNSIGNED_EN
    .req0_unsigned (req0_unsigned),
    .req1_unsigned (req1_unsigned),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_less  (rsp_less),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] v,
                         input logic l, input logic z, input logic o);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, ".less"}, 64'(rsp_less), 64'(l));
    chk({tag, ".zero"}, 64'(rsp_zero), 64'(z));
    chk({tag, ".ovf"}, 64'(rsp_ovf), 64'(o));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
`ifdef SLT_SHARE_UNSIGNED_EN
    req0_unsigned = 1'b0;
    req1_unsigned = 1'b0;
`endif
    // reset state
    #2;
    chk_rsp("rst_in", 2'b00, 0, 0, 0);
    chk("rst_in.req_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_rsp("rst_out", 2'b00, 0, 0, 0);
    chk("rst_out.req_ready", 64'(req_ready), 64'd0);

    // req0 only, -5 < 3, rsp_ready held
    rsp_ready = 2'b11;
    req0_a = 64'hFFFF_FFFF_FFFF_FFFB;
    req0_b = 64'd3;
    req_valid = 2'b01;
    #1;
    chk("single.req_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    req0_a = '0; req0_b = '0;
    chk("single.calc_valid", 64'(rsp_valid), 64'd0);
    chk("single.calc_ready", 64'(req_ready), 64'd0);
    tick();
    chk_rsp("single.rsp", 2'b01, 1, 0, 0);
    tick();
    chk("single.done", 64'(rsp_valid), 64'd0);

    // round robin from fresh priority 0
    do_reset();
    req0_a = 64'd7; req0_b = 64'd7;
    req1_a = 64'h8000_0000_0000_0000; req1_b = 64'd1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d.grant", i), 64'(req_ready),
          (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk($sformatf("rr%0d.calc", i), 64'(rsp_valid), 64'd0);
      tick();
      if (i % 2 == 0)
        chk_rsp($sformatf("rr%0d", i), 2'b01, 0, 1, 0);
      else
        chk_rsp($sformatf("rr%0d", i), 2'b10, 1, 0, 1);
      tick();
    end

    // req1 response stalled while req0 waits
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    req1_a = 64'd3; req1_b = 64'd5;
    #1;
    chk("stall.grant1", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b01;
    req0_a = 64'd3; req0_b = 64'd3;
    req1_a = '0; req1_b = '0;
    tick();
    chk_rsp("stall.rsp", 2'b10, 1, 0, 0);
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_rsp($sformatf("stall.hold%0d", i), 2'b10, 1, 0, 0);
      chk($sformatf("stall.rdy%0d", i), 64'(req_ready), 64'd0);
    end
    rsp_ready = 2'b10;
    tick();
    chk("stall.released", 64'(rsp_valid), 64'd0);
    chk("stall.grant0", 64'(req_ready), 64'd1);
    rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    tick();
    chk_rsp("stall.rsp0", 2'b01, 0, 1, 0);
    tick();

    // reset during CALC
    req0_a = 64'd1; req0_b = 64'd2;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("midrst.pre_zero", 64'(rsp_zero), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_rsp("midrst.async", 2'b00, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_rsp("midrst.noresp", 2'b00, 0, 0, 0);
    tick();
    chk("midrst.noresp2", 64'(rsp_valid), 64'd0);
    req0_a = 64'd2; req0_b = 64'd9;
    req_valid = 2'b01;
    #1;
    chk("midrst.grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk_rsp("midrst.rsp", 2'b01, 1, 0, 0);
    tick();

`ifdef SLT_SHARE_UNSIGNED_EN
    // same operands, unsigned then signed
    req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1;
    req0_unsigned = 1'b1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk_rsp("uns.rsp", 2'b01, 0, 0, 0);
    tick();
    req0_unsigned = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk_rsp("sgn.rsp", 2'b01, 1, 0, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
